// File: rtl/pio_debounce_irq.sv
// -----------------------------------------------------------------------------
// pio_debounce_irq
//
// Parallel I/O peripheral for an Avalon-MM slave port. One instance serves a
// key, switch or LED bank of any width from 1 to 32 bits.
//
// Input path, per bit:
//   two-flop synchroniser -> debouncer (or bypass) -> edge detector
//   -> sticky edge-capture bit -> AND with mask -> OR-reduce to irq
// Output path:
//   write-only output register on out_port, with readback at its own offset.
//
// Parameters
//   DATA_W           width of in_port / out_port (1..32)
//   DEBOUNCE_CYCLES  clock cycles per debounce sample tick; 0 = no debounce
//   EDGE_MODE        0 rising, 1 falling, 2 any edge
//   OUT_RESET        reset value of out_port
//
// Ports
//   clk_50      system clock, the only clock
//   reset_n     asynchronous active-low reset
//   address     word register offset
//                 0: R debounced input      / W out_port
//                 1: R/W irq mask
//                 2: R edge capture         / W 1-to-clear
//                 3: R out_port readback    / W ignored
//   chipselect  slave select, qualifies read and write
//   read        read strobe, readdata valid one cycle later
//   write       write strobe, takes effect at the next clock edge
//   writedata   write data, bits at and above DATA_W ignored
//   readdata    registered read data, zero-extended, held between reads
//   irq         level interrupt: OR of (edge capture AND mask)
//   in_port     raw asynchronous inputs
//   out_port    output register
// -----------------------------------------------------------------------------
module pio_debounce_irq #(
    parameter int                DATA_W          = 10,
    parameter int                DEBOUNCE_CYCLES = 1000,
    parameter int                EDGE_MODE       = 2,
    parameter logic [DATA_W-1:0] OUT_RESET       = '0
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port
);

    // -------------------------------------------------------------------------
    // Register offsets
    // -------------------------------------------------------------------------
    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd1;
    localparam logic [1:0] OFF_EDGE = 2'd2;
    localparam logic [1:0] OFF_OUT  = 2'd3;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] sync1_reg;
    logic [DATA_W-1:0] sync2_reg;
    logic [DATA_W-1:0] deb_reg;
    logic [DATA_W-1:0] deb_next;
    logic [DATA_W-1:0] deb_prev_reg;
    logic [DATA_W-1:0] edge_det;
    logic [DATA_W-1:0] edge_cap_reg;
    logic [DATA_W-1:0] edge_cap_next;
    logic [DATA_W-1:0] cap_clr;
    logic [DATA_W-1:0] mask_reg;
    logic [DATA_W-1:0] out_reg;
    logic [31:0]       readdata_reg;
    logic [31:0]       rd_mux;
    logic [DATA_W-1:0] wdata;
    logic              wr_en;
    logic              rd_en;

    // Upper writedata bits have no register behind them; folding them into a
    // named sink keeps the intent explicit.
    logic              unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & write;
    assign rd_en = chipselect & read;
    assign wdata = writedata[DATA_W-1:0];

    // -------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous inputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync2_next(sync1_reg);
        end
    end

    // Identity helper; keeps the second stage visibly a plain copy.
    function automatic logic [DATA_W-1:0] sync2_next(input logic [DATA_W-1:0] s1);
        return s1;
    endfunction

    // -------------------------------------------------------------------------
    // Debouncer
    // -------------------------------------------------------------------------
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No tick counter or history: the debounced value simply follows
            // the synchronised input one cycle later.
            assign deb_next = sync2_reg;
        end else begin : g_debounce
            localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_reg;
            logic             tick;

            // Free-running sample-tick counter, 0..DEBOUNCE_CYCLES-1.
            assign tick = (cnt_reg == CNT_LAST);

            always_ff @(posedge clk_50 or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else if (tick) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
                logic [2:0] hist_reg;
                logic [2:0] hist_next;

                // Newest sample enters at bit 0.
                assign hist_next = {hist_reg[1:0], sync2_reg[gi]};

                always_ff @(posedge clk_50 or negedge reset_n) begin
                    if (!reset_n) begin
                        hist_reg <= '0;
                    end else if (tick) begin
                        hist_reg <= hist_next;
                    end
                end

                // The bit flips at the tick that completes three matching
                // samples of the opposite level. Using hist_next rather than
                // hist_reg lets deb change on that third tick itself instead
                // of one cycle after it.
                assign deb_next[gi] = (tick && (hist_next == {3{~deb_reg[gi]}}))
                                      ? ~deb_reg[gi] : deb_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            deb_reg      <= '0;
            deb_prev_reg <= '0;
        end else begin
            deb_reg      <= deb_next;
            deb_prev_reg <= deb_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Edge detection; deb and deb_prev both reset to 0 so reset release never
    // looks like an edge.
    // -------------------------------------------------------------------------
    generate
        if (EDGE_MODE == 0) begin : g_rise
            assign edge_det = deb_reg & ~deb_prev_reg;
        end else if (EDGE_MODE == 1) begin : g_fall
            assign edge_det = ~deb_reg & deb_prev_reg;
        end else begin : g_any
            assign edge_det = deb_reg ^ deb_prev_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Edge capture with write-1-to-clear. The set term is ORed in after the
    // clear so a new edge is never lost to a clear landing in the same cycle.
    // -------------------------------------------------------------------------
    assign cap_clr       = (wr_en && (address == OFF_EDGE)) ? wdata : '0;
    assign edge_cap_next = (edge_cap_reg & ~cap_clr) | edge_det;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap_reg <= '0;
        end else begin
            edge_cap_reg <= edge_cap_next;
        end
    end

    // -------------------------------------------------------------------------
    // Mask and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg <= '0;
            out_reg  <= OUT_RESET;
        end else if (wr_en) begin
            if (address == OFF_MASK) begin
                mask_reg <= wdata;
            end
            if (address == OFF_DATA) begin
                out_reg <= wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read path: one cycle latency, value held until the next read.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (address)
            OFF_DATA: rd_mux[DATA_W-1:0] = deb_reg;
            OFF_MASK: rd_mux[DATA_W-1:0] = mask_reg;
            OFF_EDGE: rd_mux[DATA_W-1:0] = edge_cap_reg;
            OFF_OUT:  rd_mux[DATA_W-1:0] = out_reg;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
        end else if (rd_en) begin
            readdata_reg <= rd_mux;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. irq is a pure AND/OR of flop outputs, so it cannot glitch on
    // bus activity.
    // -------------------------------------------------------------------------
    assign readdata = readdata_reg;
    assign out_port = out_reg;
    assign irq      = |(edge_cap_reg & mask_reg);

endmodule

// File: tb/tb_pio_debounce_irq.sv
// -----------------------------------------------------------------------------
// Directed testbench for pio_debounce_irq.
// Three instances share the bus signals and have their own chipselect:
//   dut_a: no debounce, falling edge, out_port resets to 10'h155
//   dut_b: DEBOUNCE_CYCLES=8, any edge
//   dut_c: no debounce, any edge
// -----------------------------------------------------------------------------
module tb_pio_debounce_irq;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        cs_a, cs_b, cs_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;
    logic [9:0]  in_a, in_b, in_c;
    logic [9:0]  out_a, out_b, out_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_50 = ~clk_50;

    pio_debounce_irq #(
        .DATA_W(10), .DEBOUNCE_CYCLES(0), .EDGE_MODE(1), .OUT_RESET(10'h155)
    ) dut_a (
        .clk_50(clk_50), .reset_n(reset_n), .address(address), .chipselect(cs_a),
        .read(read), .write(write), .writedata(writedata), .readdata(rd_a),
        .irq(irq_a), .in_port(in_a), .out_port(out_a)
    );

    pio_debounce_irq #(
        .DATA_W(10), .DEBOUNCE_CYCLES(8), .EDGE_MODE(2), .OUT_RESET(10'h000)
    ) dut_b (
        .clk_50(clk_50), .reset_n(reset_n), .address(address), .chipselect(cs_b),
        .read(read), .write(write), .writedata(writedata), .readdata(rd_b),
        .irq(irq_b), .in_port(in_b), .out_port(out_b)
    );

    pio_debounce_irq #(
        .DATA_W(10), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2), .OUT_RESET(10'h000)
    ) dut_c (
        .clk_50(clk_50), .reset_n(reset_n), .address(address), .chipselect(cs_c),
        .read(read), .write(write), .writedata(writedata), .readdata(rd_c),
        .irq(irq_c), .in_port(in_c), .out_port(out_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic select(input int sel);
        cs_a = (sel == 0);
        cs_b = (sel == 1);
        cs_c = (sel == 2);
    endtask

    task automatic bus_write(input int sel, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_50);
        select(sel);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk_50);
        select(-1);
        write = 1'b0;
        $display("write dut%0d off %0d data %h", sel, a, d);
    endtask

    task automatic bus_read(input int sel, input logic [1:0] a, output logic [31:0] d);
        @(negedge clk_50);
        select(sel);
        address = a;
        read    = 1'b1;
        @(negedge clk_50);
        select(-1);
        read = 1'b0;
        d = (sel == 0) ? rd_a : (sel == 1) ? rd_b : rd_c;
        $display("read  dut%0d off %0d data %h", sel, a, d);
    endtask

    initial begin : main
        logic [31:0] rdv;
        int          j;

        reset_n   = 1'b1;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'h0;
        select(-1);
        in_a = 10'h000;
        in_b = 10'h000;
        in_c = 10'h000;

        // ---- 1. Asynchronous reset asserted mid-clock ----
        @(posedge clk_50);
        @(posedge clk_50);
        #3 reset_n = 1'b0;
        #1;
        check("rst_out_a", out_a, 32'h155);
        check("rst_irq_a", irq_a, 32'h0);
        check("rst_rd_a",  rd_a,  32'h0);
        check("rst_out_b", out_b, 32'h0);
        repeat (3) @(negedge clk_50);
        reset_n = 1'b1;
        bus_read(0, 2'd0, rdv); check("rst_off0", rdv, 32'h0);
        bus_read(0, 2'd1, rdv); check("rst_off1", rdv, 32'h0);
        bus_read(0, 2'd2, rdv); check("rst_off2", rdv, 32'h0);
        bus_read(0, 2'd3, rdv); check("rst_off3", rdv, 32'h155);

        // ---- 2. Bypass path, falling edge, exact irq latency, W1C ----
        @(negedge clk_50);
        in_a[0] = 1'b1;
        repeat (5) @(negedge clk_50);
        check("rise_ignored_irq", irq_a, 32'h0);
        bus_read(0, 2'd2, rdv); check("rise_ignored_cap", rdv, 32'h0);
        bus_read(0, 2'd0, rdv); check("bypass_deb_hi", rdv, 32'h1);
        bus_write(0, 2'd1, 32'h1);
        @(negedge clk_50);
        in_a[0] = 1'b0;                 // change before edge k
        @(negedge clk_50); check("irq_after_k",   irq_a, 32'h0);
        @(negedge clk_50); check("irq_after_k1",  irq_a, 32'h0);
        @(negedge clk_50); check("irq_after_k2",  irq_a, 32'h0);
        @(negedge clk_50); check("irq_after_k3",  irq_a, 32'h1);
        bus_read(0, 2'd2, rdv); check("fall_cap", rdv, 32'h1);
        bus_read(0, 2'd0, rdv); check("bypass_deb_lo", rdv, 32'h0);
        check("irq_before_w1c", irq_a, 32'h1);
        bus_write(0, 2'd2, 32'h1);
        check("irq_after_w1c", irq_a, 32'h0);

        // ---- 3. Debounce glitch rejection and latency ----
        bus_write(1, 2'd1, 32'h8);
        @(negedge clk_50);
        in_b[3] = 1'b1;
        repeat (10) @(negedge clk_50);
        in_b[3] = 1'b0;
        repeat (50) @(negedge clk_50);
        check("glitch_irq", irq_b, 32'h0);
        bus_read(1, 2'd0, rdv); check("glitch_deb", rdv, 32'h0);
        bus_read(1, 2'd2, rdv); check("glitch_cap", rdv, 32'h0);
        @(negedge clk_50);
        in_b[3] = 1'b1;                 // change before edge k, sync2 at k+1
        j = 0;
        while (irq_b !== 1'b1 && j < 60) begin
            @(negedge clk_50);
            j++;
        end
        // deb within 27 cycles of sync2 (k+28 at latest), irq one edge later;
        // three ticks 8 apart need at least k+18 for deb, so irq no sooner than k+19
        check("deb_latency_in_range", (j >= 19 && j <= 29) ? 32'h1 : 32'h0, 32'h1);
        repeat (10) @(negedge clk_50);
        bus_read(1, 2'd0, rdv); check("held_deb", rdv, 32'h8);
        bus_read(1, 2'd2, rdv); check("held_cap", rdv, 32'h8);

        // ---- 4. Set and W1C clear on the same bit in the same cycle ----
        bus_write(2, 2'd1, 32'h4);
        @(negedge clk_50);
        in_c[2] = 1'b1;
        repeat (5) @(negedge clk_50);
        check("coll_pre_irq", irq_c, 32'h1);
        @(negedge clk_50);
        in_c[2] = 1'b0;                 // before edge k; capture sets at k+3
        @(negedge clk_50);
        @(negedge clk_50);
        @(negedge clk_50);
        select(2);                      // W1C lands on edge k+3
        address   = 2'd2;
        writedata = 32'h4;
        write     = 1'b1;
        @(negedge clk_50);
        select(-1);
        write = 1'b0;
        $display("write dut2 off 2 data %h (same edge as capture)", 32'h4);
        check("coll_irq", irq_c, 32'h1);
        bus_read(2, 2'd2, rdv); check("coll_cap", rdv, 32'h4);
        bus_write(2, 2'd2, 32'h4);
        check("coll_plain_w1c_irq", irq_c, 32'h0);

        // ---- 5. Masking ----
        bus_write(2, 2'd1, 32'h0);
        bus_write(2, 2'd2, 32'h3FF);
        @(negedge clk_50);
        in_c = in_c | 10'h201;
        repeat (6) @(negedge clk_50);
        check("masked_irq", irq_c, 32'h0);
        bus_read(2, 2'd2, rdv); check("masked_cap", rdv, 32'h201);
        bus_write(2, 2'd1, 32'h200);
        check("unmask_irq", irq_c, 32'h1);
        bus_read(2, 2'd1, rdv); check("mask_readback", rdv, 32'h200);

        // ---- 6. Output register and readback ----
        bus_write(0, 2'd0, 32'hFFFF_FC3A);
        check("out_write", out_a, 32'h03A);
        bus_read(0, 2'd3, rdv); check("out_readback", rdv, 32'h0000_003A);
        bus_write(0, 2'd3, 32'h0000_03FF);
        check("out_ro_offset3", out_a, 32'h03A);
        bus_read(0, 2'd3, rdv); check("out_readback2", rdv, 32'h0000_003A);
        repeat (3) @(negedge clk_50);
        check("readdata_hold", rd_a, 32'h0000_003A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pio_debounce_irq.md
# pio_debounce_irq

Parametrised Avalon-MM parallel I/O peripheral for the Nios II system bus. It serves key, switch and LED banks of any width from one block. Each input bit passes through a synchroniser and a debouncer, then programmable edge detection sets maskable interrupt bits. A write-only output register drives LEDs and can be read back. It replaces the fixed-width, polled key/sw/led PIOs with one reusable, interrupt-capable block.

## Interface
Parameters:
- DATA_W, 10, width of in_port/out_port; 1..32.
- DEBOUNCE_CYCLES, 1000, clock cycles per debounce sample tick; 0 = debounce bypassed.
- EDGE_MODE, 2, capture edge: 0 rising, 1 falling, 2 any.
- OUT_RESET, 0, reset value of out_port (DATA_W bits).

Ports:
- clk_50  in  1  system clock; the only clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  word register offset.
- chipselect  in  1  slave select.
- read  in  1  read strobe; qualified by chipselect.
- write  in  1  write strobe; qualified by chipselect.
- writedata  in  32  write data; bits above DATA_W ignored.
- readdata  out  32  read data, registered; zero-extended above DATA_W.
- irq  out  1  level interrupt request to CPU.
- in_port  in  DATA_W  raw asynchronous inputs (keys/switches).
- out_port  out  DATA_W  output register (LEDs).

## Operation
- Register map:
  - Offset 0: read gives debounced input; write loads out_port.
  - Offset 1: irq mask, R/W.
  - Offset 2: edge capture; read returns it, writing 1 clears that bit (W1C).
  - Offset 3: read gives out_port readback; writes ignored.
- Synchroniser: two flops per bit: sync1 <= in_port, then sync2 <= sync1.
- Tick counter: counts 0..DEBOUNCE_CYCLES-1 and wraps. tick = 1 in the cycle the count equals DEBOUNCE_CYCLES-1.
- Debounce, DEBOUNCE_CYCLES > 0:
  - On each tick, every bit shifts sync2 into a 3-entry history.
  - A bit of deb updates when its 3 history entries are equal and differ from deb.
  - Bits debounce independently.
- Debounce, DEBOUNCE_CYCLES = 0: deb <= sync2 every cycle; no tick counter is built.
- Edge detection:
  - deb_prev <= deb every cycle.
  - Rising edge = deb & ~deb_prev. Falling edge = ~deb & deb_prev. Any edge = deb ^ deb_prev. EDGE_MODE selects which.
- Edge capture: each bit is set by a detected edge and held until cleared by W1C.
  - A set and a W1C clear on the same bit in the same cycle: set wins.
- irq = |(edge_cap & mask). Combinational from registers, so glitch-free.
  - Changing the mask takes effect the cycle after the write.
- Reset values:
  - readdata 0; irq 0; out_port OUT_RESET; mask 0; edge_cap 0.
  - deb 0, deb_prev 0, history all 0, sync flops 0, tick counter 0.
  - No edge is captured when reset releases.
- Reset mid-debounce discards history. Inputs already held high reappear as rising edges after the debounce delay. This is the required behaviour.

## Timing
- Slave timing: read latency 1, zero wait states, write latency 0.
  - readdata is valid the cycle after chipselect&read.
  - readdata holds its value while no read is issued.
- A written value appears on the register/out_port at the next clock edge.
- Bypass input path, with in_port changing before edge k:
  - sync2 at edge k+1; deb at k+2.
  - edge_cap set at k+3; irq high after k+3 if the bit is masked in.
- Debounced path: deb changes on the third tick at which the new sync2 value is sampled. Latency is 2..3·DEBOUNCE_CYCLES + 3 cycles.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES can never change deb.
  - A pulse present on only 1 or 2 consecutive ticks is also rejected.
- W1C clear of offset 2 at edge k: irq low after edge k, unless a new edge sets the bit in the same cycle.

## Test plan
1. Reset:
   - DATA_W=10, OUT_RESET=10'h155; assert reset_n=0 mid-clock.
   - out_port=10'h155, irq=0 and readdata=0 immediately (asynchronous). All registers read 0 except offset 3 = 10'h155.
2. Bypass edge and IRQ:
   - DEBOUNCE_CYCLES=0, EDGE_MODE=1, mask=10'h001; drive in_port[0] 1→0.
   - Offset 2 reads 10'h001; irq rises exactly 3 edges after the input change.
   - W1C write of 1 to offset 2 drops irq the next cycle.
3. Debounce glitch rejection:
   - DEBOUNCE_CYCLES=8; pulse in_port[3] high for 10 cycles → deb unchanged, no capture.
   - Hold it high for 40 cycles → offset 0 bit 3 = 1 within 27 cycles of sync2, and the capture bit is set.
4. Set/clear collision: in EDGE_MODE=2, force an edge on bit 2 in the same cycle as a W1C of bit 2 → bit 2 remains 1 and irq stays high.
5. Masking:
   - Capture edges on bits 0 and 9 with mask=0 → irq=0, offset 2 reads 10'h201.
   - Write mask=10'h200 → irq=1 the next cycle.
6. Output/readback: write 32'hFFFF_FC3A to offset 0 → out_port=10'h03A, offset 3 reads 32'h0000_003A, and a write to offset 3 has no effect.
